// File: rtl/irq_ctrl.sv
// Interrupt controller: rising-edge capture into PENDING, fixed priority (highest index wins),
// a REQ/GAP handshake toward the core, and a small always-granted register slave.
module irq_ctrl #(
    parameter int          NUM_SRC   = 32,
    parameter logic [31:0] BASE_ADDR = 32'h0000_4000
) (
    input  logic               clk,
    input  logic               res,
    input  logic [NUM_SRC-1:0] irq_src,
    input  logic               data_req,
    output logic               data_gnt,
    output logic               data_r_valid,
    input  logic [31:0]        data_adr,
    input  logic               data_write_enable,
    input  logic [31:0]        data_write,
    output logic [31:0]        data_read,
    output logic               irq,
    output logic [4:0]         irq_id,
    input  logic               irq_ack,
    input  logic [4:0]         irq_ack_id
);

    localparam logic [31:0] SRC_MASK = 32'hFFFF_FFFF >> (32 - NUM_SRC);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        GAP  = 2'd2
    } state_t;

    state_t             state_q;
    logic [NUM_SRC-1:0] src_q;
    logic [31:0]        enable_q, enable_d;
    logic [31:0]        pending_q, pending_d;
    logic [31:0]        rdata_q, rdata_d;
    logic               rvalid_q;
    logic               irq_q;
    logic [4:0]         irq_id_q;

    logic [31:0] src_ext, srcq_ext, edge_ev;
    logic [31:0] sw_set, w1c, ack_clr, cand;
    logic [4:0]  winner;
    logic        hit, wr;
    logic [1:0]  off;
    logic        unused_adr;

    assign unused_adr = ^data_adr[1:0];

    assign hit = (data_adr[31:4] == BASE_ADDR[31:4]);
    assign off = data_adr[3:2];
    assign wr  = data_req & data_write_enable & hit;

    always_comb begin
        src_ext                = '0;
        srcq_ext               = '0;
        src_ext[NUM_SRC-1:0]   = irq_src;
        srcq_ext[NUM_SRC-1:0]  = src_q;
        edge_ev                = src_ext & ~srcq_ext & SRC_MASK;

        sw_set  = (wr && off == 2'd2) ? (data_write & SRC_MASK) : 32'd0;
        w1c     = (wr && off == 2'd1) ? (data_write & SRC_MASK) : 32'd0;
        ack_clr = '0;
        if (irq_ack && ({27'd0, irq_ack_id} < 32'(NUM_SRC)))
            ack_clr[irq_ack_id] = 1'b1;

        // Sets are ORed in after clears so a coincident event is never lost.
        pending_d = (pending_q & ~(w1c | ack_clr)) | edge_ev | sw_set;
        enable_d  = (wr && off == 2'd0) ? (data_write & SRC_MASK) : enable_q;

        rdata_d = '0;
        if (data_req && !data_write_enable && hit) begin
            case (off)
                2'd0:    rdata_d = enable_q;
                2'd1:    rdata_d = pending_q;
                default: rdata_d = '0;
            endcase
        end

        cand   = pending_q & enable_q;
        winner = '0;
        for (int i = 0; i < 32; i++) begin
            if (cand[i])
                winner = 5'(i);
        end
    end

    always_ff @(posedge clk) begin
        // Sampled during reset too, so lines already high do not fire afterwards.
        src_q <= irq_src;
        if (res) begin
            state_q   <= IDLE;
            irq_q     <= 1'b0;
            irq_id_q  <= '0;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
            enable_q  <= '0;
            pending_q <= '0;
        end else begin
            enable_q  <= enable_d;
            pending_q <= pending_d;
            rvalid_q  <= data_req;
            rdata_q   <= rdata_d;
            case (state_q)
                IDLE: begin
                    if (cand != 32'd0) begin
                        state_q  <= REQ;
                        irq_q    <= 1'b1;
                        irq_id_q <= winner;
                    end
                end
                REQ: begin
                    // Leave on ack, or when software withdraws the presented source.
                    if (irq_ack || !pending_q[irq_id_q] || !enable_q[irq_id_q]) begin
                        state_q <= GAP;
                        irq_q   <= 1'b0;
                    end
                end
                GAP: begin
                    state_q <= IDLE;
                    irq_q   <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                    irq_q   <= 1'b0;
                end
            endcase
        end
    end

    assign data_gnt     = data_req;
    assign data_r_valid = rvalid_q;
    assign data_read    = rdata_q;
    assign irq          = irq_q;
    assign irq_id       = irq_id_q;

endmodule

// File: tb/tb_irq_ctrl.sv
// Directed bench for irq_ctrl: register access table plus hand-written interrupt sequences.
module tb_irq_ctrl;

    localparam logic [31:0] BASE = 32'h0000_4000;

    logic        clk = 1'b0;
    logic        res;
    logic [31:0] irq_src;
    logic        data_req, data_gnt, data_r_valid, data_write_enable;
    logic [31:0] data_adr, data_write, data_read;
    logic        irq, irq_ack;
    logic [4:0]  irq_id, irq_ack_id;

    int total = 0;
    int bad   = 0;

    irq_ctrl #(.NUM_SRC(32), .BASE_ADDR(BASE)) dut (
        .clk(clk), .res(res), .irq_src(irq_src),
        .data_req(data_req), .data_gnt(data_gnt), .data_r_valid(data_r_valid),
        .data_adr(data_adr), .data_write_enable(data_write_enable),
        .data_write(data_write), .data_read(data_read),
        .irq(irq), .irq_id(irq_id), .irq_ack(irq_ack), .irq_ack_id(irq_ack_id)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [31:0] adr;
        logic [31:0] wd;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[17];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One bus transaction followed by an idle cycle; returns the read data.
    task automatic bus_op(input logic we, input logic [31:0] adr, input logic [31:0] wd,
                          output logic [31:0] rd);
        data_req          = 1'b1;
        data_write_enable = we;
        data_adr          = adr;
        data_write        = wd;
        #1;
        chk("gnt", {31'd0, data_gnt}, 32'd1);
        tick();
        chk("rvalid_hi", {31'd0, data_r_valid}, 32'd1);
        rd                = data_read;
        data_req          = 1'b0;
        data_write_enable = 1'b0;
        data_write        = '0;
        tick();
        chk("rvalid_lo", {31'd0, data_r_valid}, 32'd0);
        chk("rdata_idle", data_read, 32'd0);
    endtask

    task automatic do_reset();
        res = 1'b1;
        tick();
        tick();
        res = 1'b0;
    endtask

    logic [31:0] rd;

    initial begin
        res = 1'b1; irq_src = '0; data_req = 1'b0; data_adr = BASE;
        data_write_enable = 1'b0; data_write = '0; irq_ack = 1'b0; irq_ack_id = '0;

        vecs[0]  = '{1'b0, BASE + 32'h0,  32'h0,         32'h0};
        vecs[1]  = '{1'b1, BASE + 32'h0,  32'hA5A5_0F0F, 32'h0};
        vecs[2]  = '{1'b0, BASE + 32'h0,  32'h0,         32'hA5A5_0F0F};
        vecs[3]  = '{1'b0, BASE + 32'h4,  32'h0,         32'h0};
        vecs[4]  = '{1'b1, BASE + 32'h8,  32'h0000_0300, 32'h0};
        vecs[5]  = '{1'b0, BASE + 32'h4,  32'h0,         32'h0000_0300};
        vecs[6]  = '{1'b0, BASE + 32'h8,  32'h0,         32'h0};
        vecs[7]  = '{1'b1, BASE + 32'h4,  32'h0000_0100, 32'h0};
        vecs[8]  = '{1'b0, BASE + 32'h4,  32'h0,         32'h0000_0200};
        vecs[9]  = '{1'b1, BASE + 32'hC,  32'hFFFF_FFFF, 32'h0};
        vecs[10] = '{1'b0, BASE + 32'hC,  32'h0,         32'h0};
        vecs[11] = '{1'b1, BASE + 32'h10, 32'h1234_5678, 32'h0};
        vecs[12] = '{1'b0, BASE + 32'h0,  32'h0,         32'hA5A5_0F0F};
        vecs[13] = '{1'b0, BASE + 32'h10, 32'h0,         32'h0};
        vecs[14] = '{1'b1, BASE + 32'h4,  32'h0000_0200, 32'h0};
        vecs[15] = '{1'b0, BASE + 32'h4,  32'h0,         32'h0};
        vecs[16] = '{1'b1, BASE + 32'h0,  32'h0,         32'h0};

        // Test 1: reset with a line held high; no event afterwards.
        irq_src = 32'h0000_0008;
        do_reset();
        chk("rst_irq", {31'd0, irq}, 32'd0);
        chk("rst_id", {27'd0, irq_id}, 32'd0);
        chk("rst_rvalid", {31'd0, data_r_valid}, 32'd0);
        chk("rst_rdata", data_read, 32'd0);
        bus_op(1'b1, BASE + 32'h0, 32'hFFFF_FFFF, rd);
        tick();
        chk("t1_irq", {31'd0, irq}, 32'd0);
        bus_op(1'b0, BASE + 32'h4, 32'h0, rd);
        chk("t1_pending", rd, 32'd0);
        irq_src = '0;

        // Register table.
        do_reset();
        for (int i = 0; i < 17; i++) begin
            bus_op(vecs[i].we, vecs[i].adr, vecs[i].wd, rd);
            if (!vecs[i].we)
                chk($sformatf("vec%0d", i), rd, vecs[i].exp);
        end

        // Test 2: single source, latency and ack.
        do_reset();
        bus_op(1'b1, BASE + 32'h0, 32'h0000_0001, rd);
        irq_src = 32'h1;
        tick();
        chk("t2_irq_N", {31'd0, irq}, 32'd0);
        irq_src = '0;
        tick();
        chk("t2_irq_N1", {31'd0, irq}, 32'd1);
        chk("t2_id", {27'd0, irq_id}, 32'd0);
        irq_ack = 1'b1; irq_ack_id = 5'd0;
        tick();
        irq_ack = 1'b0;
        chk("t2_irq_ack", {31'd0, irq}, 32'd0);
        bus_op(1'b0, BASE + 32'h4, 32'h0, rd);
        chk("t2_pending", rd, 32'd0);

        // Test 3: sources 7 and 2 together; 7 first, then 2 after the gap.
        do_reset();
        bus_op(1'b1, BASE + 32'h0, 32'h0000_0084, rd);
        irq_src = 32'h84;
        tick();
        irq_src = '0;
        tick();
        chk("t3_irq", {31'd0, irq}, 32'd1);
        chk("t3_id7", {27'd0, irq_id}, 32'd7);
        irq_ack = 1'b1; irq_ack_id = 5'd7;
        tick();
        irq_ack = 1'b0;
        chk("t3_gap", {31'd0, irq}, 32'd0);
        tick();
        chk("t3_idle", {31'd0, irq}, 32'd0);
        tick();
        chk("t3_irq2", {31'd0, irq}, 32'd1);
        chk("t3_id2", {27'd0, irq_id}, 32'd2);

        // Test 4: software withdraw via W1C while in REQ; unmapped offset read.
        do_reset();
        bus_op(1'b1, BASE + 32'h0, 32'h0000_0020, rd);
        irq_src = 32'h20;
        tick();
        irq_src = '0;
        tick();
        chk("t4_irq", {31'd0, irq}, 32'd1);
        chk("t4_id5", {27'd0, irq_id}, 32'd5);
        bus_op(1'b1, BASE + 32'h4, 32'h0000_0020, rd);
        chk("t4_withdraw", {31'd0, irq}, 32'd0);
        bus_op(1'b0, BASE + 32'h4, 32'h0, rd);
        chk("t4_pending", rd, 32'd0);
        bus_op(1'b0, BASE + 32'hC, 32'h0, rd);
        chk("t4_rd_c", rd, 32'd0);

        // Test 5: new edge on source 4 coincides with its ack.
        do_reset();
        bus_op(1'b1, BASE + 32'h0, 32'h0000_0010, rd);
        irq_src = 32'h10;
        tick();
        irq_src = '0;
        tick();
        chk("t5_id4", {27'd0, irq_id}, 32'd4);
        irq_src = 32'h10; irq_ack = 1'b1; irq_ack_id = 5'd4;
        tick();
        irq_src = '0; irq_ack = 1'b0;
        chk("t5_gap", {31'd0, irq}, 32'd0);
        tick();
        chk("t5_idle", {31'd0, irq}, 32'd0);
        tick();
        chk("t5_reirq", {31'd0, irq}, 32'd1);
        chk("t5_reid", {27'd0, irq_id}, 32'd4);
        bus_op(1'b0, BASE + 32'h4, 32'h0, rd);
        chk("t5_pending", rd, 32'h10);

        // Test 6: SW_SET request, then reset mid-REQ.
        do_reset();
        bus_op(1'b1, BASE + 32'h8, 32'h0000_0100, rd);
        bus_op(1'b1, BASE + 32'h0, 32'h0000_0100, rd);
        chk("t6_irq", {31'd0, irq}, 32'd1);
        chk("t6_id8", {27'd0, irq_id}, 32'd8);
        res = 1'b1;
        tick();
        chk("t6_rst_irq", {31'd0, irq}, 32'd0);
        res = 1'b0;
        bus_op(1'b0, BASE + 32'h4, 32'h0, rd);
        chk("t6_pending", rd, 32'd0);
        bus_op(1'b0, BASE + 32'h0, 32'h0, rd);
        chk("t6_enable", rd, 32'd0);
        chk("t6_irq_after", {31'd0, irq}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
